// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// opcode/funct constants and the datapath mux / ALU operation codes.
package multicycle_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;

    typedef enum logic [STATE_W-1:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_REXE = 4'd6,
        S_RWB  = 4'd7,
        S_BR   = 4'd8,
        S_JMP  = 4'd9,
        S_IEXE = 4'd10,
        S_IWB  = 4'd11
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

    localparam logic [OPCODE_W-1:0] FN_JR    = 6'b001000;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10,
        PC_REG_A  = 2'b11
    } pc_src_t;

    typedef enum logic [1:0] {
        DST_RT = 2'b00,
        DST_RD = 2'b01,
        DST_RA = 2'b10
    } reg_dst_t;

    typedef enum logic [1:0] {
        WB_ALUOUT = 2'b00,
        WB_MDR    = 2'b01,
        WB_PC     = 2'b10
    } mem_to_reg_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_LUI   = 3'b101
    } alu_op_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-wait cycles and flags the cycle on which the
// wait limit is reached. MEM_TIMEOUT = 0 disables the timeout.
//  clk, rst_n : clock, async active-low reset
//  count_en   : a memory wait is in progress this cycle (mem_ready low)
//  clear      : restart counting (state change or timeout)
//  timeout    : this wait cycle is the MEM_TIMEOUT-th one
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    input  logic clear,
    output logic timeout
);

    localparam int unsigned CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    logic [CW-1:0] count;

    // Saturating counter so a disabled timeout never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign timeout = (MEM_TIMEOUT != 0) && count_en && (count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core. Sequences each instruction
// through fetch/decode/execute/memory/writeback and decodes the datapath
// mux selects and write enables from the current state.
//  inputs : clk, rst_n, opcode/funct (from IR), zero (ALU flag), mem_ready
//  outputs: memory handshake (mem_req, mem_we, iord), register enables
//           (ir_en, pc_en, reg_we), mux selects (alu_src_a/b, pc_src,
//           reg_dst, mem_to_reg), ext_sign, alu_op, and status pulses
//           (instr_done, illegal_op, mem_err)
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_en,
    output logic       pc_en,
    output logic       reg_we,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_sign,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_err
);

    state_t state, next_state;
    logic   is_jr;
    logic   wait_state;
    logic   timer_clear;
    logic   timeout;

    assign is_jr       = (opcode == OP_RTYPE) && (funct == FN_JR);
    assign wait_state  = (state == S_IF) || (state == S_MRD) || (state == S_MWR);
    assign timer_clear = (next_state != state) || timeout;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .count_en (wait_state && !mem_ready),
        .clear    (timer_clear),
        .timeout  (timeout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IF;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; mem_ready takes priority over a coinciding timeout
    always_comb begin
        next_state = state;
        case (state)
            S_IF:   if (mem_ready) next_state = S_ID;
            S_ID: begin
                case (opcode)
                    OP_LW, OP_SW:                      next_state = S_MADR;
                    OP_RTYPE:                          next_state = is_jr ? S_JMP : S_REXE;
                    OP_BEQ, OP_BNE:                    next_state = S_BR;
                    OP_J, OP_JAL:                      next_state = S_JMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  next_state = S_IEXE;
                    default:                           next_state = S_IF;
                endcase
            end
            S_MADR: next_state = (opcode == OP_SW) ? S_MWR : S_MRD;
            S_MRD: begin
                if (mem_ready)    next_state = S_MWB;
                else if (timeout) next_state = S_IF;
            end
            S_MWR:  if (mem_ready || timeout) next_state = S_IF;
            S_REXE: next_state = S_RWB;
            S_IEXE: next_state = S_IWB;
            default: next_state = S_IF;
        endcase
    end

    // Output decode (Moore, except ir_en/pc_en qualified by mem_ready/zero)
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_en      = 1'b0;
        pc_en      = 1'b0;
        reg_we     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        ext_sign   = 1'b0;
        alu_op     = ALU_ADD;
        pc_src     = PC_ALU;
        reg_dst    = DST_RT;
        mem_to_reg = WB_ALUOUT;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        mem_err    = 1'b0;
        case (state)
            S_IF: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_en     = mem_ready;
                pc_en     = mem_ready;
                mem_err   = timeout;
            end
            S_ID: begin
                alu_src_b  = SRCB_IMM_SH2;
                ext_sign   = 1'b1;
                illegal_op = (next_state == S_IF);
            end
            S_MADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ext_sign  = 1'b1;
            end
            S_MRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_err = timeout;
            end
            S_MWR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
                mem_err    = timeout;
            end
            S_MWB: begin
                reg_we     = 1'b1;
                mem_to_reg = WB_MDR;
                instr_done = 1'b1;
            end
            S_REXE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                reg_we     = 1'b1;
                reg_dst    = DST_RD;
                instr_done = 1'b1;
            end
            S_IEXE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ext_sign  = (opcode == OP_ADDI);
                case (opcode)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_LUI:  alu_op = ALU_LUI;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_IWB: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
            end
            S_BR: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_src     = PC_ALUOUT;
                pc_en      = zero ^ (opcode == OP_BNE);
                instr_done = 1'b1;
            end
            S_JMP: begin
                pc_en      = 1'b1;
                pc_src     = is_jr ? PC_REG_A : PC_JUMP;
                instr_done = 1'b1;
                // jal links the already-incremented PC into $31
                if (opcode == OP_JAL) begin
                    reg_we     = 1'b1;
                    reg_dst    = DST_RA;
                    mem_to_reg = WB_PC;
                end
            end
            default: ;
        endcase
        // Enables and pulses are held off for as long as reset is asserted
        if (!rst_n) begin
            pc_en      = 1'b0;
            ir_en      = 1'b0;
            reg_we     = 1'b0;
            mem_we     = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
            mem_err    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Three instances (MEM_TIMEOUT 16, 4
// and 0) share stimulus; expected outputs come from a per-phase table of the
// instruction sequencing rules.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_en;
        logic       pc_en;
        logic       reg_we;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_sign;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       instr_done;
        logic       illegal_op;
        logic       mem_err;
    } outs_t;

    localparam int P_FETCH = 0, P_DECODE = 1, P_ADDR = 2, P_MEMRD = 3, P_MEMWR = 4,
                   P_MEMWB = 5, P_REXE = 6, P_RWB = 7, P_IEXE = 8, P_IWB = 9,
                   P_BR = 10, P_JMP = 11;
    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_IMM = 3, C_BR = 4, C_J = 5, C_ILL = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    outs_t      obs [3];

    int checks = 0;
    int errors = 0;
    int cyc;
    int done_at;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int unsigned TOV = (gi == 0) ? 16 : ((gi == 1) ? 4 : 0);
        logic       mem_req, mem_we, iord, ir_en, pc_en, reg_we, alu_src_a, ext_sign;
        logic       instr_done, illegal_op, mem_err;
        logic [1:0] alu_src_b, pc_src, reg_dst, mem_to_reg;
        logic [2:0] alu_op;
        multicycle_ctrl #(.MEM_TIMEOUT(TOV)) dut (
            .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
            .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
            .ir_en(ir_en), .pc_en(pc_en), .reg_we(reg_we), .alu_src_a(alu_src_a),
            .alu_src_b(alu_src_b), .ext_sign(ext_sign), .alu_op(alu_op), .pc_src(pc_src),
            .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
            .illegal_op(illegal_op), .mem_err(mem_err)
        );
        assign obs[gi] = {mem_req, mem_we, iord, ir_en, pc_en, reg_we, alu_src_a, alu_src_b,
                          ext_sign, alu_op, pc_src, reg_dst, mem_to_reg, instr_done,
                          illegal_op, mem_err};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic int classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b000000: return (f == 6'b001000) ? C_J : C_R;
            6'b000010, 6'b000011: return C_J;
            6'b000100, 6'b000101: return C_BR;
            6'b001000, 6'b001100, 6'b001101, 6'b001111: return C_IMM;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            default: return C_ILL;
        endcase
    endfunction

    function automatic int min_cycles(input int cls);
        case (cls)
            C_LW:       return 5;
            C_BR, C_J:  return 3;
            default:    return 4;
        endcase
    endfunction

    // Expected outputs (e) and which fields are defined in that phase (m)
    function automatic void exp_of(input int ph, input logic [5:0] o, input logic [5:0] f,
                                   input logic rdy, input logic z, input logic to,
                                   output outs_t e, output outs_t m);
        e = '0;
        m = '0;
        m.mem_req = 1'b1; m.mem_we = 1'b1; m.ir_en = 1'b1; m.pc_en = 1'b1; m.reg_we = 1'b1;
        m.instr_done = 1'b1; m.illegal_op = 1'b1; m.mem_err = 1'b1;
        case (ph)
            P_FETCH: begin
                e.mem_req = 1'b1; e.ir_en = rdy; e.pc_en = rdy; e.alu_src_b = 2'b01;
                e.mem_err = to;
                m.iord = 1'b1; m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_op = 3'b111;
                m.pc_src = 2'b11;
            end
            P_DECODE: begin
                e.alu_src_b = 2'b11; e.ext_sign = 1'b1;
                e.illegal_op = (classify(o, f) == C_ILL);
                m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.ext_sign = 1'b1; m.alu_op = 3'b111;
            end
            P_ADDR: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.ext_sign = 1'b1;
                m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.ext_sign = 1'b1; m.alu_op = 3'b111;
            end
            P_MEMRD, P_MEMWR: begin
                e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (ph == P_MEMWR);
                e.instr_done = (ph == P_MEMWR) && rdy; e.mem_err = to;
                m.iord = 1'b1;
            end
            P_MEMWB: begin
                e.reg_we = 1'b1; e.mem_to_reg = 2'b01; e.instr_done = 1'b1;
                m.reg_dst = 2'b11; m.mem_to_reg = 2'b11;
            end
            P_REXE: begin
                e.alu_src_a = 1'b1; e.alu_op = 3'b010;
                m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_op = 3'b111;
            end
            P_RWB, P_IWB: begin
                e.reg_we = 1'b1; e.reg_dst = (ph == P_RWB) ? 2'b01 : 2'b00; e.instr_done = 1'b1;
                m.reg_dst = 2'b11; m.mem_to_reg = 2'b11;
            end
            P_IEXE: begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.ext_sign = (o == 6'b001000);
                e.alu_op = (o == 6'b001100) ? 3'b011 : (o == 6'b001101) ? 3'b100 :
                           (o == 6'b001111) ? 3'b101 : 3'b000;
                m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.ext_sign = 1'b1; m.alu_op = 3'b111;
            end
            P_BR: begin
                e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_src = 2'b01;
                e.pc_en = z ^ (o == 6'b000101); e.instr_done = 1'b1;
                m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_op = 3'b111; m.pc_src = 2'b11;
            end
            P_JMP: begin
                e.pc_en = 1'b1; e.instr_done = 1'b1;
                e.pc_src = (o == 6'b000000 && f == 6'b001000) ? 2'b11 : 2'b10;
                m.pc_src = 2'b11;
                if (o == 6'b000011) begin
                    e.reg_we = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
                    m.reg_dst = 2'b11; m.mem_to_reg = 2'b11;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic check_inst(input int k, input int ph, input logic rdy, input logic to);
        outs_t e, m;
        exp_of(ph, opcode, funct, rdy, zero, to, e, m);
        chk($sformatf("u%0d ph%0d op=%b fn=%b", k, ph, opcode, funct),
            32'(obs[k] & m), 32'(e & m));
    endtask

    // One clock of stimulus: drive mem_ready, check all instances, advance
    task automatic cycle(input int ph, input logic rdy);
        mem_ready = rdy;
        #2;
        cyc++;
        if (obs[0].instr_done && done_at < 0) done_at = cyc;
        for (int k = 0; k < 3; k++) check_inst(k, ph, rdy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int sif, input int smem);
        int cls;
        int q[$];
        opcode = o; funct = f; zero = z;
        cyc = 0; done_at = -1;
        cls = classify(o, f);
        for (int i = 0; i <= sif; i++) cycle(P_FETCH, i == sif);
        cycle(P_DECODE, 1'($urandom));
        case (cls)
            C_LW:    q = '{P_ADDR, P_MEMRD, P_MEMWB};
            C_SW:    q = '{P_ADDR, P_MEMWR};
            C_R:     q = '{P_REXE, P_RWB};
            C_IMM:   q = '{P_IEXE, P_IWB};
            C_BR:    q = '{P_BR};
            C_J:     q = '{P_JMP};
            default: q = {};
        endcase
        foreach (q[i]) begin
            if (q[i] == P_MEMRD || q[i] == P_MEMWR) begin
                for (int s = 0; s <= smem; s++) cycle(q[i], s == smem);
            end else begin
                cycle(q[i], 1'($urandom));
            end
        end
        if (cls != C_ILL && sif == 0 && smem == 0)
            chk($sformatf("cycles op=%b", o), 32'(done_at), 32'(min_cycles(cls)));
    endtask

    function automatic logic [5:0] pick_op(input int i);
        case (i)
            0: return 6'b100011;  1: return 6'b101011;  2: return 6'b000000;
            3: return 6'b001000;  4: return 6'b001100;  5: return 6'b001101;
            6: return 6'b001111;  7: return 6'b000100;  8: return 6'b000101;
            9: return 6'b000010; 10: return 6'b000011; 11: return 6'b111111;
            default: return 6'b010001;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        #3;
        // Reset: IF decode with enables forced low even though mem_ready=1
        for (int k = 0; k < 3; k++) check_inst(k, P_FETCH, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_instr(6'b100011, 6'd0, 1'b0, 0, 0);        // lw
        run_instr(6'b000100, 6'd0, 1'b1, 0, 0);        // beq taken
        run_instr(6'b000101, 6'd0, 1'b1, 0, 0);        // bne not taken
        run_instr(6'b000011, 6'd0, 1'b0, 0, 0);        // jal
        run_instr(6'b000000, 6'b100000, 1'b0, 3, 0);   // add, 3-cycle fetch stall
        run_instr(6'b111111, 6'd0, 1'b0, 0, 0);        // illegal
        run_instr(6'b000000, 6'b001000, 1'b0, 0, 0);   // jr
        run_instr(6'b101011, 6'd0, 1'b0, 0, 3);        // sw, write stall

        for (int n = 0; n < 80; n++) begin
            run_instr(pick_op($urandom_range(0, 12)), 6'($urandom), 1'($urandom),
                      ($urandom % 2) ? 0 : $urandom_range(0, 3),
                      ($urandom % 2) ? 0 : $urandom_range(0, 3));
        end

        // Read that never completes: timeout at the 4th / 16th wait, never for 0
        opcode = 6'b100011; funct = '0; cyc = 0; done_at = -1;
        cycle(P_FETCH, 1'b1);
        cycle(P_DECODE, 1'b1);
        cycle(P_ADDR, 1'b1);
        for (int w = 1; w <= 20; w++) begin
            mem_ready = 1'b0;
            #2;
            if (w <= 16)      check_inst(0, P_MEMRD, 1'b0, 1'(w == 16));
            else if (w == 17) check_inst(0, P_FETCH, 1'b0, 1'b0);
            if (w <= 4)       check_inst(1, P_MEMRD, 1'b0, 1'(w == 4));
            else if (w == 5)  check_inst(1, P_FETCH, 1'b0, 1'b0);
            check_inst(2, P_MEMRD, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset asserted in the middle of a stalled store
        opcode = 6'b101011; cyc = 0; done_at = -1;
        cycle(P_FETCH, 1'b1);
        cycle(P_DECODE, 1'b1);
        cycle(P_ADDR, 1'b1);
        cycle(P_MEMWR, 1'b0);
        cycle(P_MEMWR, 1'b0);
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst mid-MWR mem_we", 32'(obs[0].mem_we), 32'd0);
        for (int k = 0; k < 3; k++) check_inst(k, P_FETCH, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_instr(6'b101011, 6'd0, 1'b0, 0, 0);
        run_instr(6'b001111, 6'd0, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
